// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package serial_adder_pkg;

    localparam int SA_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_fa_bit.sv
// Single-bit full adder used by the serial adder datapath.
// Ports: a, b, c (inputs) -> s (sum bit), co (carry out).
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per clock, LSB first, result after WIDTH cycles.
// Ports: clk, reset (async high), start, a, b, cin -> busy, done, sum, cout.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_co;
    logic             accept;

    fa_bit u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .c  (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Start is honoured in IDLE and DONE, never mid-operation.
    assign accept = start && (state_q != RUN);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        if (accept) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            cnt_d   = '0;
            state_d = RUN;
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                RUN: begin
                    a_d     = a_q >> 1;
                    b_d     = b_q >> 1;
                    carry_d = fa_co;
                    // New bit enters at the MSB; written as a shift/or so
                    // it stays legal when WIDTH is 1.
                    sum_d   = (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        cout_d  = fa_co;
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder (WIDTH=8 and WIDTH=1 instances).
// Each scenario task drives stimulus and checks results inline.
module tb_serial_adder;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int pass_cnt;
    int total_cnt;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge; the next edge accepts; returns in RUN cycle 1.
    task automatic launch(input logic [7:0] av, input logic [7:0] bv,
                          input logic cv);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output int n, output bit ok);
        n = 0;
        while (!done && n < maxc) begin
            step();
            n++;
        end
        ok = done;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        a1 = '0; b1 = '0; cin1 = 1'b0;
        step();
        step();
        total_cnt++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            $display("FAIL reset8: busy=%b done=%b sum=%h cout=%b want all 0",
                     busy, done, sum, cout);
        end else pass_cnt++;
        total_cnt++;
        if ({busy1, done1, sum1, cout1} !== 4'd0) begin
            $display("FAIL reset1: busy=%b done=%b sum=%b cout=%b want all 0",
                     busy1, done1, sum1, cout1);
        end else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int bc;
        int dc;
        bc = 0;
        dc = 0;
        launch(8'h5A, 8'h3C, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            if (busy) bc++;
            if (done) dc++;
            step();
        end
        total_cnt++;
        if (bc != 8 || dc != 0) begin
            $display("FAIL basic_busy: busy_cycles=%0d done_cycles=%0d want 8/0",
                     bc, dc);
        end else pass_cnt++;
        total_cnt++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL basic_done9: done=%b busy=%b want 1/0", done, busy);
        end else pass_cnt++;
        total_cnt++;
        if (sum !== 8'h96 || cout !== 1'b0) begin
            $display("FAIL basic_sum: sum=%h cout=%b want 96/0", sum, cout);
        end else pass_cnt++;
        step();
        total_cnt++;
        if (done !== 1'b0 || sum !== 8'h96 || cout !== 1'b0) begin
            $display("FAIL basic_hold: done=%b sum=%h cout=%b want 0/96/0",
                     done, sum, cout);
        end else pass_cnt++;
    endtask

    task automatic test_overflow();
        int n;
        bit ok;
        launch(8'hFF, 8'h01, 1'b0);
        wait_done(20, n, ok);
        total_cnt++;
        if (!ok || n != 8) begin
            $display("FAIL ovf1_latency: ok=%0d cycles=%0d want 1/8", ok, n);
        end else pass_cnt++;
        total_cnt++;
        if (sum !== 8'h00 || cout !== 1'b1) begin
            $display("FAIL ovf1_sum: sum=%h cout=%b want 00/1", sum, cout);
        end else pass_cnt++;
        step();
        launch(8'hFF, 8'hFF, 1'b1);
        wait_done(20, n, ok);
        total_cnt++;
        if (!ok || sum !== 8'hFF || cout !== 1'b1) begin
            $display("FAIL ovf2_sum: ok=%0d sum=%h cout=%b want 1/ff/1",
                     ok, sum, cout);
        end else pass_cnt++;
        step();
    endtask

    task automatic test_ignore_start();
        int dc;
        logic [7:0] got;
        dc  = 0;
        got = 8'h00;
        launch(8'h5A, 8'h3C, 1'b0);
        step();
        step();
        a     = 8'h11;
        b     = 8'h22;
        cin   = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (done) begin
                dc++;
                got = sum;
            end
            step();
        end
        total_cnt++;
        if (dc != 1) begin
            $display("FAIL ignore_pulses: done_pulses=%0d want 1", dc);
        end else pass_cnt++;
        total_cnt++;
        if (got !== 8'h96) begin
            $display("FAIL ignore_sum: sum=%h want 96", got);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int dc;
        int n;
        bit ok;
        dc = 0;
        launch(8'hFF, 8'h00, 1'b0);
        step();
        step();
        step();
        reset = 1'b1;
        #1;
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            $display("FAIL rstmid_async: busy=%b done=%b sum=%h cout=%b want 0/0/00/0",
                     busy, done, sum, cout);
        end else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done) dc++;
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) dc++;
            step();
        end
        total_cnt++;
        if (dc != 0) begin
            $display("FAIL rstmid_nodone: done_pulses=%0d want 0", dc);
        end else pass_cnt++;
        launch(8'h01, 8'h01, 1'b0);
        wait_done(20, n, ok);
        total_cnt++;
        if (!ok || sum !== 8'h02 || cout !== 1'b0) begin
            $display("FAIL rstmid_after: ok=%0d sum=%h cout=%b want 1/02/0",
                     ok, sum, cout);
        end else pass_cnt++;
        step();
    endtask

    task automatic test_back_to_back();
        int n;
        bit ok;
        launch(8'h03, 8'h04, 1'b0);
        wait_done(20, n, ok);
        total_cnt++;
        if (!ok || sum !== 8'h07) begin
            $display("FAIL b2b_first: ok=%0d sum=%h want 1/07", ok, sum);
        end else pass_cnt++;
        a     = 8'h10;
        b     = 8'h20;
        cin   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        total_cnt++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL b2b_restart: busy=%b done=%b want 1/0", busy, done);
        end else pass_cnt++;
        wait_done(20, n, ok);
        total_cnt++;
        if (!ok || n + 1 != 9) begin
            $display("FAIL b2b_gap: ok=%0d gap=%0d want 1/9", ok, n + 1);
        end else pass_cnt++;
        total_cnt++;
        if (sum !== 8'h30 || cout !== 1'b0) begin
            $display("FAIL b2b_sum: sum=%h cout=%b want 30/0", sum, cout);
        end else pass_cnt++;
        step();
    endtask

    task automatic test_width1();
        logic [7:0] s_tab;
        logic [7:0] c_tab;
        logic [2:0] v;
        s_tab = 8'b1001_0110;
        c_tab = 8'b1110_1000;
        for (int i = 0; i < 8; i++) begin
            v      = 3'(i);
            a1     = v[2];
            b1     = v[1];
            cin1   = v[0];
            start1 = 1'b1;
            step();
            start1 = 1'b0;
            total_cnt++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                $display("FAIL w1_run_%0d: busy=%b done=%b want 1/0",
                         i, busy1, done1);
            end else pass_cnt++;
            step();
            total_cnt++;
            if (done1 !== 1'b1 || sum1[0] !== s_tab[i] || cout1 !== c_tab[i]) begin
                $display("FAIL w1_fa_%0d: done=%b sum=%b cout=%b want 1/%b/%b",
                         i, done1, sum1, cout1, s_tab[i], c_tab[i]);
            end else pass_cnt++;
            step();
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_width1();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand width in bits, legal range 1..32.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to begin an addition; sampled on the clk rising edge.
REQ-005 SHALL have port: a  input  WIDTH  first operand; captured when start is accepted.
REQ-006 SHALL have port: b  input  WIDTH  second operand; captured when start is accepted.
REQ-007 SHALL have port: cin  input  1  carry-in; captured when start is accepted.
REQ-008 SHALL have port: busy  output  1  high while an addition is in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse marking that sum and cout are valid.
REQ-010 SHALL have port: sum  output  WIDTH  registered result.
REQ-011 SHALL have port: cout  output  1  registered final carry-out.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 SHALL accept start only in IDLE or DONE, and SHALL ignore start in RUN.
REQ-014 On the edge that accepts start, the block SHALL:
- load a and b into shift registers;
- load the carry flip-flop with cin;
- clear the bit counter;
- enter RUN.
REQ-015 SHALL process one bit per RUN edge, LSB first:
- sum bit = a0 XOR b0 XOR carry;
- carry register <= majority(a0, b0, carry);
- operand registers shift right by one.
REQ-016 SHALL shift each sum bit into the result register at the MSB end, so the result is correctly aligned after WIDTH shifts.
REQ-017 SHALL use a bit counter of $clog2(WIDTH)+1 bits, and SHALL leave RUN on the edge that processes bit WIDTH-1.
REQ-018 Latency: if start is accepted at edge k, the block SHALL assert done and present a valid sum and cout in the cycle following edge k+WIDTH.
REQ-019 SHALL hold busy high for exactly WIDTH cycles, covering the RUN state only.
REQ-020 SHALL assert done only in DONE, which lasts exactly one cycle, then SHALL return to IDLE unless start is accepted.
REQ-021 A start accepted in DONE SHALL begin a new operation immediately, giving back-to-back throughput of one result per WIDTH+1 cycles.
REQ-022 SHALL hold sum and cout stable from DONE until the next accepted start.
REQ-023 Sum and cout SHALL be undefined for outside use during RUN; the bench SHALL check them only while done is high.
REQ-024 With WIDTH=1, the block SHALL spend one cycle in RUN, then assert done, and SHALL produce sum = a^b^cin and cout = majority(a, b, cin).
REQ-025 Overflow SHALL appear only on cout; sum SHALL wrap modulo 2^WIDTH.
REQ-026 Input changes on a or b during RUN SHALL have no effect on the result.

Reset
REQ-027 While reset is high, all of the following SHALL hold asynchronously:
- state = IDLE;
- busy = 0, done = 0;
- sum = 0, cout = 0;
- carry = 0, counter = 0, operand registers = 0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-029 After reset deasserts, the first rising clk edge SHALL be able to accept start.

Structure
REQ-030 SHALL place the state enum type (IDLE/RUN/DONE) in the shared package serial_adder_pkg.
REQ-031 SHALL place the default WIDTH constant in serial_adder_pkg.
REQ-032 SHALL instantiate one combinational sub-module, fa_bit, with inputs a, b, c and outputs s, co, implementing the per-bit full-adder logic.
REQ-033 SHALL keep the carry register, shift registers, counter and FSM in the top module only.

Verification
REQ-034 The bench SHALL cover these directed scenarios (WIDTH=8 unless stated):
- a=0x5A, b=0x3C, cin=0, start at edge 0 -> done high in cycle 9; sum=0x96, cout=0; busy high cycles 1-8.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
- a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- start pulsed again during RUN with different operands -> ignored; first result unchanged; exactly one done pulse.
- reset asserted at RUN cycle 4 -> busy=0, sum=0 immediately; no done pulse; a following start (0x01+0x01) -> sum=0x02.
- start held high through the DONE cycle with a=0x10, b=0x20 -> second operation begins; second done pulse 9 cycles after the first, sum=0x30.
REQ-035 The bench SHALL also run a WIDTH=1 build with all 8 input combinations, matching the full-adder truth table.
